// File: rtl/move_repeat_input.sv
// move_repeat_input: PS/2 WASD/arrow decoder for the step-sequencer cursor.
// Emits one-cycle move pulses with auto-repeat and a one-shot Enter command.
// Ports:
//   Clock, nReset        - system clock, async active-low reset
//   Enable               - accept key actions; low clears outputs and held state
//   data[7:0], data_en   - scan-code byte and its one-cycle valid strobe
//   Direction[3:0]       - one-hot move pulse (0 up, 1 down, 2 left, 3 right)
//   Command              - one-cycle Enter pulse
//   Held[3:0]            - one-hot level of the currently held direction
module move_repeat_input #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int REPEAT_EN     = 1
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Enable,
    input  logic [7:0] data,
    input  logic       data_en,
    output logic [3:0] Direction,
    output logic       Command,
    output logic [3:0] Held
);

    localparam int MAX_RELOAD = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW = $clog2(MAX_RELOAD) + 1;
    localparam logic [CW-1:0] LOAD_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] LOAD_PERIOD = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t state, state_next;

    logic [3:0]    make_dir;
    logic [3:0]    brk_dir;
    logic          make_ent;
    logic          brk_ent;
    logic          enter_held;
    logic [CW-1:0] cnt;

    function automatic logic [3:0] plain_dir(input logic [7:0] c);
        case (c)
            8'h1D:   return 4'b0001;
            8'h1B:   return 4'b0010;
            8'h1C:   return 4'b0100;
            8'h23:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] ext_dir(input logic [7:0] c);
        case (c)
            8'h75:   return 4'b0001;
            8'h72:   return 4'b0010;
            8'h6B:   return 4'b0100;
            8'h74:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Parser runs regardless of Enable so prefixes are never lost.
    always_comb begin
        state_next = state;
        make_dir   = 4'b0000;
        brk_dir    = 4'b0000;
        make_ent   = 1'b0;
        brk_ent    = 1'b0;
        if (data_en) begin
            unique case (state)
                S_IDLE: begin
                    if (data == 8'hE0) begin
                        state_next = S_EXT;
                    end else if (data == 8'hF0) begin
                        state_next = S_BRK;
                    end else begin
                        make_dir = plain_dir(data);
                        make_ent = (data == 8'h5A);
                    end
                end
                S_EXT: begin
                    if (data == 8'hF0) begin
                        state_next = S_EXT_BRK;
                    end else begin
                        make_dir   = ext_dir(data);
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    brk_dir    = plain_dir(data);
                    brk_ent    = (data == 8'h5A);
                    state_next = S_IDLE;
                end
                S_EXT_BRK: begin
                    brk_dir    = ext_dir(data);
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // A fresh make outranks both break and expiry, so an expiry that
    // coincides with a new key or a release never produces a pulse.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Direction  <= 4'b0000;
            Command    <= 1'b0;
            Held       <= 4'b0000;
            enter_held <= 1'b0;
            cnt        <= '0;
        end else if (!Enable) begin
            Direction  <= 4'b0000;
            Command    <= 1'b0;
            Held       <= 4'b0000;
            enter_held <= 1'b0;
            cnt        <= '0;
        end else begin
            Direction <= 4'b0000;
            Command   <= 1'b0;
            if (make_dir != 4'b0000 && make_dir != Held) begin
                Held      <= make_dir;
                Direction <= make_dir;
                cnt       <= (REPEAT_EN != 0) ? LOAD_DELAY : '0;
            end else if (brk_dir != 4'b0000 && brk_dir == Held) begin
                Held <= 4'b0000;
                cnt  <= '0;
            end else if (REPEAT_EN != 0 && Held != 4'b0000) begin
                if (cnt == CNT_ONE) begin
                    Direction <= Held;
                    cnt       <= LOAD_PERIOD;
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_ONE;
                end
            end
            if (make_ent) begin
                Command    <= !enter_held;
                enter_held <= 1'b1;
            end else if (brk_ent) begin
                enter_held <= 1'b0;
            end
        end
    end

endmodule
